// File: rtl/pcmon_pkg.sv
// Shared definitions for the PC propagation monitor: monitor states,
// stage-index width and the fetch stage index.
package pcmon_pkg;

  localparam int STAGE_W = 3;
  localparam logic [STAGE_W-1:0] STAGE_FETCH = '0;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    CHECK = 2'd2
  } mon_state_t;

  // Index of the writeback (last) stage for a given pipeline depth.
  function automatic logic [STAGE_W-1:0] last_stage(input int num_stages);
    return STAGE_W'(num_stages - 1);
  endfunction

endpackage

// File: rtl/pcmon_stage_tracker.sv
// Stage tracker: holds the expected stage index of the instruction being
// followed and flags any stage-sequence or pc_write protocol violation.
module pcmon_stage_tracker
  import pcmon_pkg::*;
#(
  parameter int NUM_STAGES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  mon_state_t         state,
  input  logic [STAGE_W-1:0] stage,
  input  logic               pc_write,
  output logic [STAGE_W-1:0] exp_stage,
  output logic               seq_err,
  output logic               last_next
);

  localparam logic [STAGE_W-1:0] LAST = last_stage(NUM_STAGES);

  logic [STAGE_W-1:0] exp_stage_nxt;

  // Violation detect and next expected stage for the current monitor state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    seq_err       = 1'b0;
    exp_stage_nxt = '0;
    unique case (state)
      HUNT: begin
        // Only a fetch is interesting while hunting; a PC write there is bogus.
        seq_err = (stage == STAGE_FETCH) && pc_write;
        if ((stage == STAGE_FETCH) && !pc_write) exp_stage_nxt = STAGE_W'(1);
      end
      TRACK: begin
        seq_err = (stage != exp_stage) || pc_write;
        if (!seq_err) exp_stage_nxt = exp_stage + STAGE_W'(1);
      end
      CHECK: begin
        seq_err = (stage != exp_stage) || !pc_write;
      end
      default: begin
        seq_err       = 1'b0;
        exp_stage_nxt = '0;
      end
    endcase
  end

  assign last_next = (exp_stage_nxt == LAST);

  // Expected-stage register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    if (!rst) exp_stage <= '0;
    else      exp_stage <= exp_stage_nxt;
  end

endmodule

// File: rtl/pc_prop_monitor.sv
// PC propagation monitor: follows each instruction through the stage
// sequence, checks that the NPC written back equals fetch PC + 1, and counts
// protocol/compare errors. Define PCMON_LAST_BAD_EN to add the last_bad_pc
// capture register and port.
module pc_prop_monitor
  import pcmon_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_STAGES = 5,
  parameter int ERR_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STAGE_W-1:0] stage,
  input  logic               pc_write,
  input  logic [WIDTH-1:0]   npc_fetch,
  input  logic [WIDTH-1:0]   npc_wb,
  output logic               check_valid,
  output logic               mismatch,
  output logic               sync_err,
  output logic               locked,
  output logic [ERR_W-1:0]   err_count
`ifdef PCMON_LAST_BAD_EN
  ,
  output logic [WIDTH-1:0]   last_bad_pc
`endif
);

  mon_state_t         state, state_nxt;
  logic [WIDTH-1:0]   expected, expected_nxt;
  logic [STAGE_W-1:0] exp_stage;
  logic               seq_err, last_next;
  logic               cmp_fire, sync_fire, mismatch_nxt;

  pcmon_stage_tracker #(
    .NUM_STAGES(NUM_STAGES)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .stage     (stage),
    .pc_write  (pc_write),
    .exp_stage (exp_stage),
    .seq_err   (seq_err),
    .last_next (last_next)
  );

  // Next-state, expected-NPC capture and event decode.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    cmp_fire     = 1'b0;
    sync_fire    = 1'b0;
    unique case (state)
      HUNT: begin
        if (seq_err) begin
          sync_fire = 1'b1;
        end else if (stage == STAGE_FETCH) begin
          expected_nxt = npc_fetch + WIDTH'(1);
          state_nxt    = last_next ? CHECK : TRACK;
        end
      end
      TRACK: begin
        if (seq_err) begin
          sync_fire = 1'b1;
          state_nxt = HUNT;
        end else if (last_next) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        // Either way the instruction is finished; hunting next cycle lets a
        // back-to-back fetch lock with no bubble.
        state_nxt = HUNT;
        if (seq_err) sync_fire = 1'b1;
        else         cmp_fire  = 1'b1;
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign mismatch_nxt = cmp_fire && (npc_wb != expected);

  // Monitor state and captured expected NPC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      expected <= '0;
    end else begin
      state    <= state_nxt;
      expected <= expected_nxt;
    end
  end

  // Registered outputs and saturating error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      check_valid <= 1'b0;
      mismatch    <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      check_valid <= cmp_fire;
      mismatch    <= mismatch_nxt;
      sync_err    <= sync_fire;
      locked      <= (state_nxt != HUNT);
      if ((mismatch_nxt || sync_fire) && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);
    end
  end

`ifdef PCMON_LAST_BAD_EN
  // Most recent NPC that failed the compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              last_bad_pc <= '0;
    else if (mismatch_nxt) last_bad_pc <= npc_wb;
  end
`else
  // No last-bad-PC capture in this build.
`endif

endmodule

// File: tb/tb_pc_prop_monitor.sv
// Bench for pc_prop_monitor: directed instruction sequences, an abstract
// position-counting model compared every cycle, and literal spot checks.
module tb_pc_prop_monitor;

  localparam int LAST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  stage = 3'd7;
  logic        pc_write = 1'b0;
  logic [31:0] npc_fetch = '0;
  logic [31:0] npc_wb = '0;

  logic        cv1, mm1, se1, lk1;
  logic [15:0] ec1;
  logic        cv2, mm2, se2, lk2;
  logic [1:0]  ec2;
`ifdef PCMON_LAST_BAD_EN
  logic [31:0] lb1, lb2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_prop_monitor dut (
    .clk(clk), .rst(rst), .stage(stage), .pc_write(pc_write),
    .npc_fetch(npc_fetch), .npc_wb(npc_wb),
    .check_valid(cv1), .mismatch(mm1), .sync_err(se1), .locked(lk1),
    .err_count(ec1)
`ifdef PCMON_LAST_BAD_EN
    , .last_bad_pc(lb1)
`endif
  );

  pc_prop_monitor #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stage(stage), .pc_write(pc_write),
    .npc_fetch(npc_fetch), .npc_wb(npc_wb),
    .check_valid(cv2), .mismatch(mm2), .sync_err(se2), .locked(lk2),
    .err_count(ec2)
`ifdef PCMON_LAST_BAD_EN
    , .last_bad_pc(lb2)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_pos is the stage the followed instruction must show next,
  // or -1 when no instruction is being followed.
  int          m_pos = -1;
  logic [31:0] m_exp = '0;
  logic        m_cv = 0, m_mm = 0, m_se = 0;
  int          m_err = 0;
  logic [31:0] m_last = '0;

  always @(posedge clk or negedge rst) begin : model
    int   p;
    logic cv, mm, se;
    if (!rst) begin
      m_pos <= -1; m_exp <= '0; m_cv <= 0; m_mm <= 0; m_se <= 0;
      m_err <= 0;  m_last <= '0;
    end else begin
      p = m_pos; cv = 0; mm = 0; se = 0;
      if (p < 0) begin
        if (stage == 3'd0) begin
          if (pc_write) se = 1;
          else begin p = 1; m_exp <= npc_fetch + 32'd1; end
        end
      end else if (int'(stage) != p) begin
        se = 1; p = -1;
      end else if (p < LAST) begin
        if (pc_write) begin se = 1; p = -1; end
        else p = p + 1;
      end else begin
        if (!pc_write) se = 1;
        else begin cv = 1; mm = (npc_wb != m_exp); end
        p = -1;
      end
      m_pos <= p; m_cv <= cv; m_mm <= mm; m_se <= se;
      if (mm) m_last <= npc_wb;
      if (mm || se) m_err <= m_err + 1;
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    check("cv",      {63'd0, cv1}, {63'd0, m_cv});
    check("mm",      {63'd0, mm1}, {63'd0, m_mm});
    check("se",      {63'd0, se1}, {63'd0, m_se});
    check("locked",  {63'd0, lk1}, {63'd0, (m_pos >= 0)});
    check("err",     64'(ec1), 64'((m_err > 65535) ? 65535 : m_err));
    check("err_sat", 64'(ec2), 64'((m_err > 3) ? 3 : m_err));
    check("se_sat",  {63'd0, se2}, {63'd0, m_se});
`ifdef PCMON_LAST_BAD_EN
    check("last_bad", 64'(lb1), 64'(m_last));
`endif
  end

  // Present one input vector; returns at the next falling edge, when the
  // outputs produced by that vector are visible.
  task automatic cyc(input logic [2:0] s, input logic pw,
                     input logic [31:0] f, input logic [31:0] w);
    stage = s; pc_write = pw; npc_fetch = f; npc_wb = w;
    @(negedge clk);
  endtask

  // Full instruction: fetch at f, writeback of w at the last stage.
  task automatic instr(input logic [31:0] f, input logic [31:0] w);
    cyc(3'd0, 1'b0, f, 32'd0);
    for (int s = 1; s < LAST; s++) cyc(3'(s), 1'b0, f, 32'd0);
    cyc(3'(LAST), 1'b1, f, w);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cv", {63'd0, cv1}, 64'd0);
    check("rst_locked", {63'd0, lk1}, 64'd0);
    check("rst_err", 64'(ec1), 64'd0);
    #1 rst = 1'b1;
    cyc(3'd5, 1'b0, 32'd0, 32'd0);

    // Clean run
    cyc(3'd0, 1'b0, 32'h10, 32'd0);
    check("lock_after_fetch", {63'd0, lk1}, 64'd1);
    for (int s = 1; s < LAST; s++) cyc(3'(s), 1'b0, 32'h10, 32'd0);
    cyc(3'd4, 1'b1, 32'h10, 32'h11);
    check("clean_cv", {63'd0, cv1}, 64'd1);
    check("clean_mm", {63'd0, mm1}, 64'd0);
    check("clean_err", 64'(ec1), 64'd0);

    // Bad NPC
    instr(32'h10, 32'h12);
    check("bad_cv", {63'd0, cv1}, 64'd1);
    check("bad_mm", {63'd0, mm1}, 64'd1);
    check("bad_err", 64'(ec1), 64'd1);
`ifdef PCMON_LAST_BAD_EN
    check("bad_last", 64'(lb1), 64'h12);
`endif

    // Skipped stage, fetched back-to-back after the previous writeback
    cyc(3'd0, 1'b0, 32'h40, 32'd0);
    check("b2b_lock", {63'd0, lk1}, 64'd1);
    cyc(3'd1, 1'b0, 32'h40, 32'd0);
    cyc(3'd3, 1'b0, 32'h40, 32'd0);
    check("skip_se", {63'd0, se1}, 64'd1);
    check("skip_locked", {63'd0, lk1}, 64'd0);
    check("skip_err", 64'(ec1), 64'd2);
    instr(32'h100, 32'h101);
    check("relock_cv", {63'd0, cv1}, 64'd1);
    check("relock_mm", {63'd0, mm1}, 64'd0);

    // Early pc_write at stage 2
    cyc(3'd0, 1'b0, 32'h200, 32'd0);
    cyc(3'd1, 1'b0, 32'h200, 32'd0);
    cyc(3'd2, 1'b1, 32'h200, 32'h201);
    check("early_se", {63'd0, se1}, 64'd1);
    check("early_err", 64'(ec1), 64'd3);
    check("early_hunt", {63'd0, lk1}, 64'd0);

    // Missing pc_write at the last stage
    cyc(3'd0, 1'b0, 32'h300, 32'd0);
    for (int s = 1; s < LAST; s++) cyc(3'(s), 1'b0, 32'h300, 32'd0);
    cyc(3'd4, 1'b0, 32'h300, 32'h301);
    check("nowr_se", {63'd0, se1}, 64'd1);
    check("nowr_cv", {63'd0, cv1}, 64'd0);
    check("nowr_err", 64'(ec1), 64'd4);

    // Five mismatches: wide counter keeps going, 2-bit counter saturates
    for (int i = 0; i < 5; i++) instr(32'h1000 + 32'(i), 32'h5000 + 32'(i));
    check("sat_err_wide", 64'(ec1), 64'd9);
    check("sat_err_2b", 64'(ec2), 64'd3);
`ifdef PCMON_LAST_BAD_EN
    check("sat_last", 64'(lb1), 64'h5004);
`endif

    // Wrap-around of the expected NPC
    instr(32'hFFFF_FFFF, 32'h0);
    check("wrap_cv", {63'd0, cv1}, 64'd1);
    check("wrap_mm", {63'd0, mm1}, 64'd0);

    // Reset in the middle of an instruction
    cyc(3'd0, 1'b0, 32'h700, 32'd0);
    cyc(3'd1, 1'b0, 32'h700, 32'd0);
    cyc(3'd2, 1'b0, 32'h700, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_locked", {63'd0, lk1}, 64'd0);
    check("mid_rst_se", {63'd0, se1}, 64'd0);
    check("mid_rst_err", 64'(ec1), 64'd0);
    check("mid_rst_err2", 64'(ec2), 64'd0);
    cyc(3'd3, 1'b0, 32'h700, 32'd0);
    #1 rst = 1'b1;
    cyc(3'd3, 1'b0, 32'h700, 32'd0);
    cyc(3'd4, 1'b1, 32'h700, 32'h701);
    check("post_rst_se", {63'd0, se1}, 64'd0);
    check("post_rst_cv", {63'd0, cv1}, 64'd0);
    check("post_rst_err", 64'(ec1), 64'd0);
    instr(32'h20, 32'h21);
    check("resync_cv", {63'd0, cv1}, 64'd1);
    check("resync_mm", {63'd0, mm1}, 64'd0);

    cyc(3'd6, 1'b0, 32'd0, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_prop_monitor.md
PC_PROP_MONITOR -- requirements
Module: pc_prop_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC/NPC datapath width.
REQ-002 SHALL have parameter NUM_STAGES, default 5: pipeline stages per instruction, range 2..8.
REQ-003 SHALL have parameter ERR_W, default 16: error counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port stage, input, 3: current stage index from the stage sequencer.
REQ-007 SHALL have port pc_write, input, 1: PC write-enable issued by the sequencer.
REQ-008 SHALL have port npc_fetch, input, WIDTH: PC register output at fetch.
REQ-009 SHALL have port npc_wb, input, WIDTH: NPC value arriving at the PC input from the last stage.
REQ-010 SHALL have port check_valid, output, 1: one-cycle pulse when a writeback compare is done.
REQ-011 SHALL have port mismatch, output, 1: pulse concurrent with check_valid when npc_wb != expected.
REQ-012 SHALL have port sync_err, output, 1: one-cycle pulse on a stage-sequence or pc_write protocol violation.
REQ-013 SHALL have port locked, output, 1: high while the monitor tracks a valid sequence.
REQ-014 SHALL have port err_count, output, ERR_W: saturating count of error cycles.

Function
REQ-015 SHALL implement FSM states HUNT, TRACK, CHECK.
REQ-016 In HUNT, stage==0 SHALL capture expected = npc_fetch + 1 (mod 2^WIDTH), set exp_stage=1, and move to TRACK.
REQ-017 In HUNT, all other stage values SHALL be ignored, with no error.
REQ-018 In TRACK, stage SHALL equal exp_stage each cycle; exp_stage increments by 1 per cycle.
REQ-019 When exp_stage reaches NUM_STAGES-1, TRACK SHALL move to CHECK.
REQ-020 In CHECK, stage==NUM_STAGES-1 with pc_write=1 SHALL pulse check_valid the next cycle.
REQ-021 In that compare, mismatch SHALL pulse if npc_wb != expected.
REQ-022 After the compare, the monitor SHALL go to HUNT, accepting stage==0 on the immediately following cycle (back-to-back instructions, zero bubble).
REQ-023 Any stage != exp_stage in TRACK/CHECK SHALL pulse sync_err, deassert locked, and go to HUNT.
REQ-024 pc_write=1 in any stage other than NUM_STAGES-1 SHALL pulse sync_err and go to HUNT.
REQ-025 pc_write=0 in CHECK at the last stage SHALL pulse sync_err and go to HUNT.
REQ-026 locked SHALL be 1 in TRACK and CHECK and 0 in HUNT.
REQ-027 Output latency SHALL be one cycle: all outputs are registered.
REQ-028 err_count SHALL increment by exactly 1 in a cycle where mismatch or sync_err (or both) pulse.
REQ-029 err_count SHALL saturate at all-ones and never wrap.
REQ-030 Wrap-around: npc_fetch = all-ones SHALL give expected = 0.

Reset
REQ-031 rst low SHALL immediately force: state=HUNT, expected=0, exp_stage=0, check_valid=0, mismatch=0, sync_err=0, locked=0, err_count=0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no error pulse.
REQ-033 After rst deasserts, the monitor SHALL resynchronise on the next stage==0.

Configuration
REQ-034 With macro PCMON_LAST_BAD_EN defined, the block SHALL add output last_bad_pc [WIDTH-1:0]: reset 0, loaded with npc_wb on every mismatch, held otherwise.
REQ-035 Without PCMON_LAST_BAD_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 Shared package pcmon_pkg SHALL hold the state enum (HUNT/TRACK/CHECK), the STAGE_W=3 constant, and the STAGE_FETCH=0 constant.
REQ-037 A sub-module pcmon_stage_tracker SHALL hold exp_stage and flag sequence errors.
REQ-038 The top-level module SHALL hold the compare logic, err_count, and outputs.

Verification
REQ-039 Clean run: npc_fetch=0x10, stages 0..4, pc_write at 4, npc_wb=0x11 -> check_valid=1, mismatch=0, err_count=0.
REQ-040 Bad NPC: same sequence, npc_wb=0x12 -> check_valid=1, mismatch=1, err_count=1, last_bad_pc=0x12 (macro on).
REQ-041 Skipped stage: stages 0,1,3 -> sync_err at stage 3, locked=0; next stage 0 relocks.
REQ-042 Early pc_write at stage 2 -> sync_err=1, err_count+1, state HUNT.
REQ-043 Saturation: ERR_W=2, 5 mismatches -> err_count=3.
REQ-044 Wrap and reset: npc_fetch=0xFFFFFFFF, npc_wb=0 -> no mismatch; rst low at stage 2 -> all outputs 0, no sync_err.
